// File: rtl/imem_loader.sv
// UART 8N1 boot loader: receives a word count and little-endian words, writes them to
// instruction memory and holds the core in reset meanwhile. Optional: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              load_start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK, S_FINISH} sess_state_e;

  // Synchronizer plus one extra stage so the receiver sees clean falling edges.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, which is what forms the chain.
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e   rx_state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_byte_q;
  logic        byte_valid_q;
  logic        frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            baud_q     <= '0;
          end
        end
        RX_START: begin
          if (baud_q == HALF_M1) begin
            baud_q     <= '0;
            bit_idx_q  <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (baud_q == BIT_M1) begin
            baud_q    <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (baud_q == BIT_M1) begin
            baud_q     <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              byte_valid_q <= 1'b1;
              rx_byte_q    <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  sess_state_e       sess_q;
  logic [7:0]        cnt_lo_q;
  logic [15:0]       words_rem_q;
  logic [1:0]        byte_sel_q;
  logic [23:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic              full_q;
  logic [7:0]        xor_q;
  logic              imem_we_q, cpu_rst_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wd_q;

  logic [31:0] word_d;
  logic [15:0] count_d;
  assign word_d  = {rx_byte_q, word_q};
  assign count_d = {rx_byte_q, cnt_lo_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sess_q      <= S_IDLE;
      cnt_lo_q    <= '0;
      words_rem_q <= '0;
      byte_sel_q  <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      full_q      <= 1'b0;
      xor_q       <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_wd_q   <= '0;
      cpu_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      done_q    <= 1'b0;
      case (sess_q)
        S_IDLE: begin
          if (load_start) begin
            busy_q      <= 1'b1;
            cpu_rst_q   <= 1'b1;
            err_q       <= 1'b0;
            addr_q      <= '0;
            imem_addr_q <= '0;
            full_q      <= 1'b0;
            byte_sel_q  <= '0;
            xor_q       <= '0;
            sess_q      <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (byte_valid_q) begin
            cnt_lo_q <= rx_byte_q;
            xor_q    <= xor_q ^ rx_byte_q;
            sess_q   <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (byte_valid_q) begin
            words_rem_q <= count_d;
            xor_q       <= xor_q ^ rx_byte_q;
            if (count_d == 16'd0) sess_q <= CHK_EN ? S_CHECK : S_FINISH;
            else                  sess_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (byte_valid_q) begin
            xor_q      <= xor_q ^ rx_byte_q;
            byte_sel_q <= byte_sel_q + 2'd1;
            word_q     <= {rx_byte_q, word_q[23:8]};
            if (byte_sel_q == 2'd3) begin
              // Past the top of memory the word is swallowed and flagged; the address never wraps.
              if (!full_q) begin
                imem_we_q   <= 1'b1;
                imem_addr_q <= addr_q;
                imem_wd_q   <= word_d;
                if (addr_q == '1) full_q <= 1'b1;
                else              addr_q <= addr_q + ADDR_W'(1);
              end else begin
                err_q <= 1'b1;
              end
              words_rem_q <= words_rem_q - 16'd1;
              if (words_rem_q == 16'd1) sess_q <= CHK_EN ? S_CHECK : S_FINISH;
            end
          end
        end
        S_CHECK: begin
          if (byte_valid_q) begin
            if (rx_byte_q != xor_q) err_q <= 1'b1;
            sess_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          cpu_rst_q <= err_q | frame_err_q;
          sess_q    <= S_IDLE;
        end
        default: sess_q <= S_IDLE;
      endcase
      if (frame_err_q) err_q <= 1'b1;
    end
  end

  assign imem_we   = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_wd   = imem_wd_q;
  assign cpu_rst   = cpu_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
